z80_bitop_rmw_seq: RTL and testbench

Z80_BITOP_RMW_SEQ -- requirements
Module: z80_bitop_rmw_seq

---
 rtl/z80_bitop_pkg.sv | 21 ++
 rtl/z80_bitop_alu.sv | 25 ++
 rtl/z80_bitop_rmw_seq.sv | 148 ++++++++++++++
 tb/tb_z80_bitop_rmw_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/z80_bitop_pkg.sv
// Shared definitions for the Z80 bit-op read-modify-write sequencer:
// op encodings, FSM state enum and the bit-mask helper.
package z80_bitop_pkg;

  localparam logic [1:0] OP_RES = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_BIT = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [7:0] bit_mask(input logic [2:0] b);
    return 8'h01 << b;
  endfunction

endpackage

// File: rtl/z80_bitop_alu.sv
// Combinational bit-op datapath: modified byte for SET/RES and the Z flag
// for BIT, both derived from the byte just read.
module z80_bitop_alu
  import z80_bitop_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] bit_sel,
  input  logic [7:0] rdata,
  output logic [7:0] wdata,
  output logic       zero
);

  logic [7:0] mask;

  always_comb begin
    mask = bit_mask(bit_sel);
    case (op)
      OP_SET:  wdata = rdata | mask;
      OP_RES:  wdata = rdata & ~mask;
      default: wdata = rdata;
    endcase
    zero = ~rdata[bit_sel];
  end

endmodule

// File: rtl/z80_bitop_rmw_seq.sv
// Z80 SET/RES/BIT read-modify-write sequencer with ack timeout.
// Define Z80_BITOP_BIT_TEST_EN to enable BIT; otherwise op=10 is illegal and flags read 0.
module z80_bitop_rmw_seq
  import z80_bitop_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [2:0]  bit_sel,
  input  logic [15:0] hl,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        flag_z,
  output logic        flag_h,
  output logic        flag_n
);

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [2:0]  bit_q;
  logic [15:0] hl_q;
  logic [7:0]  wdata_q;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic [7:0]  alu_wdata;
  logic        alu_zero;
  logic        op_legal;
  logic        timeout;

  z80_bitop_alu u_alu (
    .op      (op_q),
    .bit_sel (bit_q),
    .rdata   (mem_rdata),
    .wdata   (alu_wdata),
    .zero    (alu_zero)
  );

  always_comb begin
`ifdef Z80_BITOP_BIT_TEST_EN
    op_legal = (op != OP_ILL);
`else
    op_legal = (op == OP_RES) || (op == OP_SET);
`endif
  end

  // Fires on the ACK_TIMEOUT-th consecutive cycle of an unacked request.
  assign timeout = !mem_ack && (wait_cnt == 8'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = op_legal ? ST_RD : ST_DONE;
      ST_RD: begin
        if (mem_ack)      state_nxt = (op_q == OP_BIT) ? ST_DONE : ST_WR;
        else if (timeout) state_nxt = ST_DONE;
      end
      ST_WR:   if (mem_ack || timeout) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_RES;
      bit_q    <= 3'd0;
      hl_q     <= 16'h0000;
      wdata_q  <= 8'h00;
      wait_cnt <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            bit_q    <= bit_sel;
            hl_q     <= hl;
            wait_cnt <= 8'h00;
            err_q    <= !op_legal;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            wdata_q  <= alu_wdata;
            wait_cnt <= 8'h00;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WR: begin
          if (!mem_ack) begin
            if (timeout) err_q <= 1'b1;
            else         wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Requests decode straight from state so an async reset drops them at once.
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_DONE) && err_q;
  assign mem_rd_req = (state == ST_RD);
  assign mem_wr_req = (state == ST_WR);
  assign mem_addr   = hl_q;
  assign mem_wdata  = wdata_q;

`ifdef Z80_BITOP_BIT_TEST_EN
  logic fz_q, fh_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fz_q <= 1'b0;
      fh_q <= 1'b0;
    end else if (state == ST_RD && mem_ack && op_q == OP_BIT) begin
      fz_q <= alu_zero;
      fh_q <= 1'b1;
    end
  end

  assign flag_z = fz_q;
  assign flag_h = fh_q;
  assign flag_n = 1'b0;
`else
  logic unused_zero;
  assign unused_zero = alu_zero;
  assign flag_z = 1'b0;
  assign flag_h = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bitop_rmw_seq.sv
// Directed bench for z80_bitop_rmw_seq: main instance with default timeout,
// second instance with ACK_TIMEOUT=4 for the timeout scenario.
module tb_z80_bitop_rmw_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start_t;
  logic [1:0]  op;
  logic [2:0]  bit_sel;
  logic [15:0] hl;
  logic [7:0]  mem_rdata;
  logic        mem_ack, ack_t;

  logic        busy, done, err, rd_req, wr_req, fz, fh, fn;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy_t, done_t, err_t, rd_t, wr_t, fz_t, fh_t, fn_t;
  logic [15:0] addr_t;
  logic [7:0]  wdata_t;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  z80_bitop_rmw_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .bit_sel(bit_sel), .hl(hl),
    .busy(busy), .done(done), .err(err), .mem_rd_req(rd_req), .mem_wr_req(wr_req),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .flag_z(fz), .flag_h(fh), .flag_n(fn)
  );

  z80_bitop_rmw_seq #(.ACK_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_n(reset_n), .start(start_t), .op(op), .bit_sel(bit_sel), .hl(hl),
    .busy(busy_t), .done(done_t), .err(err_t), .mem_rd_req(rd_t), .mem_wr_req(wr_t),
    .mem_addr(addr_t), .mem_wdata(wdata_t), .mem_rdata(mem_rdata), .mem_ack(ack_t),
    .flag_z(fz_t), .flag_h(fh_t), .flag_n(fn_t)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    logic saw_done;

    reset_n = 1'b0; start = 1'b0; start_t = 1'b0; op = 2'b00; bit_sel = 3'd0;
    hl = 16'h0000; mem_rdata = 8'h00; mem_ack = 1'b0; ack_t = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_reqs", {rd_req, wr_req}, 0);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_flags", {fz, fh, fn}, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // SET b3 @1234, rdata 00, ack held high (ack in IDLE must be ignored)
    mem_ack = 1'b1;
    step();
    chk("idle_ack_ignored", busy, 0);
    start = 1'b1; op = 2'b01; bit_sel = 3'd3; hl = 16'h1234; mem_rdata = 8'h00;
    step();
    start = 1'b0;
    chk("set_c1_rd", {rd_req, wr_req}, 2'b10);
    chk("set_c1_addr", addr, 16'h1234);
    step();
    chk("set_c2_wr", {rd_req, wr_req}, 2'b01);
    chk("set_c2_wdata", wdata, 8'h08);
    chk("set_c2_addr", addr, 16'h1234);
    step();
    chk("set_c3_done", {done, err}, 2'b10);
    chk("set_c3_reqs", {rd_req, wr_req}, 0);
    mem_ack = 1'b0;
    step();
    chk("set_idle", {busy, done}, 0);

    // BIT b0 @0042, rdata FE
    start = 1'b1; op = 2'b10; bit_sel = 3'd0; hl = 16'h0042; mem_rdata = 8'hFE; mem_ack = 1'b1;
    step();
    start = 1'b0;
`ifdef Z80_BITOP_BIT_TEST_EN
    chk("bit_c1_rd", {rd_req, wr_req}, 2'b10);
    chk("bit_c1_addr", addr, 16'h0042);
    step();
    chk("bit_c2_done", {done, err}, 2'b10);
    chk("bit_c2_nowr", wr_req, 0);
    chk("bit_flags", {fz, fh, fn}, 3'b110);
`else
    chk("bit_ill_c1", {done, err}, 2'b11);
    chk("bit_ill_noreq", {rd_req, wr_req}, 0);
    chk("bit_ill_flags", {fz, fh, fn}, 0);
`endif
    mem_ack = 1'b0;
    step();
    chk("bit_idle", busy, 0);

    // RES b7 @FFFF, rdata FF, read ack delayed 5 cycles
    start = 1'b1; op = 2'b00; bit_sel = 3'd7; hl = 16'hFFFF; mem_rdata = 8'hFF;
    step();
    start = 1'b0;
    chk("res_addr_ffff", addr, 16'hFFFF);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (rd_req) cnt++;
      step();
    end
    mem_ack = 1'b1;
    if (rd_req) cnt++;
    step();
    chk("res_rd_held", cnt, 6);
    chk("res_wr", {rd_req, wr_req}, 2'b01);
    chk("res_wdata", wdata, 8'h7F);
    step();
    chk("res_done", {done, err}, 2'b10);
`ifdef Z80_BITOP_BIT_TEST_EN
    chk("res_flags_hold", {fz, fh, fn}, 3'b110);
`else
    chk("res_flags_hold", {fz, fh, fn}, 0);
`endif
    mem_ack = 1'b0;
    step();

    // Illegal op; start in DONE must be ignored
    start = 1'b1; op = 2'b11;
    step();
    chk("ill_done_err", {done, err}, 2'b11);
    chk("ill_noreq", {rd_req, wr_req}, 0);
    op = 2'b01;
    step();
    start = 1'b0;
    chk("ill_start_in_done", {busy, rd_req}, 0);
    step();
    chk("ill_stay_idle", busy, 0);

    // Timeout on second instance: write ack never comes
    start_t = 1'b1; op = 2'b01; bit_sel = 3'd1; hl = 16'h5555; mem_rdata = 8'h00; ack_t = 1'b1;
    step();
    start_t = 1'b0;
    chk("to_rd", rd_t, 1);
    step();
    ack_t = 1'b0;
    chk("to_wdata", wdata_t, 8'h02);
    cnt = 0; guard = 0;
    while (!done_t && guard < 20) begin
      if (wr_t) cnt++;
      guard++;
      step();
    end
    chk("to_wr_cycles", cnt, 4);
    chk("to_done_err", {done_t, err_t}, 2'b11);
    chk("to_req_dropped", {rd_t, wr_t}, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd_t || wr_t || busy_t) cnt++;
    end
    chk("to_quiet", cnt, 0);

    // Reset asserted during WR
    start = 1'b1; op = 2'b01; bit_sel = 3'd2; hl = 16'h1111; mem_rdata = 8'h00; mem_ack = 1'b1;
    step();
    start = 1'b0;
    step();
    mem_ack = 1'b0;
    chk("rwr_in_wr", wr_req, 1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rwr_req_drop", {rd_req, wr_req}, 0);
    chk("rwr_busy", busy, 0);
    step();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    chk("rwr_no_done", saw_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
